// File: rtl/pifo_pkg.sv
// pifo_pkg
//   Shared constants for the 16-entry register PIFO and its ingress scheduler,
//   plus helpers that split the 12-bit PIFO meta word into {port, tag}.
//   Meta layout: port field in the top bits (MSB = META_PORT_MSB), tag below.
package pifo_pkg;

   localparam int PIFO_RANK_W   = 16;
   localparam int PIFO_META_W   = 12;
   localparam int PIFO_DEPTH    = 16;
   localparam int META_PORT_MSB = PIFO_META_W - 1;

   // Width of the port field for a requester count (never below one bit).
   function automatic int port_w(input int nports);
      return (nports > 1) ? $clog2(nports) : 1;
   endfunction

   // Tag width left over once the port field is taken from the meta word.
   function automatic int tag_w(input int nports);
      return PIFO_META_W - port_w(nports);
   endfunction

endpackage

// File: rtl/pifo_sched_if.sv
// pifo_sched_if
//   Ingress (NPORTS ranked requesters, flattened) and egress (single
//   valid/ready stream) handshake bundle of the PIFO scheduler.
//   master : traffic source/sink side (drives in_*, out_ready)
//   slave  : the scheduler (drives in_ready, out_*)
interface pifo_sched_if
   import pifo_pkg::*;
#(
   parameter int NPORTS = 4,
   parameter int RANK_W = 16,
   parameter int TAG_W  = 10
);
   localparam int PW = port_w(NPORTS);

   logic [NPORTS-1:0]        in_valid;
   logic [NPORTS-1:0]        in_ready;
   logic [NPORTS*RANK_W-1:0] in_rank;
   logic [NPORTS*TAG_W-1:0]  in_tag;
   logic                     out_valid;
   logic                     out_ready;
   logic [RANK_W-1:0]        out_rank;
   logic [PW-1:0]            out_port;
   logic [TAG_W-1:0]         out_tag;

   modport master (
      output in_valid, in_rank, in_tag, out_ready,
      input  in_ready, out_valid, out_rank, out_port, out_tag
   );

   modport slave (
      input  in_valid, in_rank, in_tag, out_ready,
      output in_ready, out_valid, out_rank, out_port, out_tag
   );
endinterface

// File: rtl/pifo_sched_rr_arb.sv
// pifo_sched_rr_arb
//   Round-robin arbiter. Searches req starting at the pointer; the pointer
//   moves to winner+1 only when advance is strobed.
//   clk, rst (async, active-low) | req in | advance in |
//   grant (one-hot) out | grant_idx out | grant_any out
module pifo_sched_rr_arb
   import pifo_pkg::*;
#(
   parameter int NPORTS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NPORTS-1:0]         req,
   input  logic                      advance,
   output logic [NPORTS-1:0]         grant,
   output logic [port_w(NPORTS)-1:0] grant_idx,
   output logic                      grant_any
);
   localparam int PW = port_w(NPORTS);

   logic [PW-1:0] ptr_r;
   logic [PW-1:0] cand_s;

   // Priority search from ptr_r; NPORTS is a power of two so index math wraps.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      cand_s    = '0;
      for (int i = 0; i < NPORTS; i++) begin
         cand_s    = ptr_r + PW'(i);
         grant_idx = (req[cand_s] && !grant_any) ? cand_s : grant_idx;
         grant_any = grant_any | req[cand_s];
      end
      grant = grant_any ? (NPORTS'(1) << grant_idx) : '0;
   end

   // Pointer register: moves past the winner on an accepted or dropped transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_r <= '0;
      end else if (advance) begin
         ptr_r <= grant_idx + PW'(1);
      end
   end
endmodule

// File: rtl/pifo_sched.sv
// pifo_sched
//   Ingress scheduler for the 16-entry register PIFO placed beside it.
//   Arbitrates NPORTS requesters onto the PIFO insert port, interleaves
//   insert/remove (never both in one cycle) and drains the PIFO head into a
//   registered valid/ready egress stage.
//   Ports: clk, rst (async, active-low) | io (pifo_sched_if.slave: in_*, out_*)
//          pifo_insert/pifo_remove/pifo_rank_in/pifo_meta_in (commands to PIFO)
//          pifo_valid_out/pifo_empty/pifo_full/pifo_rank_out/pifo_meta_out (PIFO state)
//          drop_cnt (only with PIFO_SCHED_DROP_EN): per-port saturating drop counters
//   Optional build macro: PIFO_SCHED_DROP_EN -- drop ingress packets while the
//   PIFO is full instead of back-pressuring.
module pifo_sched
   import pifo_pkg::*;
#(
   parameter int NPORTS = 4,
   parameter int RANK_W = 16,
   parameter int TAG_W  = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   pifo_sched_if.slave            io,
   output logic                   pifo_insert,
   output logic                   pifo_remove,
   output logic [PIFO_RANK_W-1:0] pifo_rank_in,
   output logic [PIFO_META_W-1:0] pifo_meta_in,
   input  logic                   pifo_valid_out,
   input  logic                   pifo_empty,
   input  logic                   pifo_full,
   input  logic [PIFO_RANK_W-1:0] pifo_rank_out,
   input  logic [PIFO_META_W-1:0] pifo_meta_out
`ifdef PIFO_SCHED_DROP_EN
   ,
   output logic [NPORTS*16-1:0]   drop_cnt
`endif
);
   localparam int PW = port_w(NPORTS);

   logic [NPORTS-1:0] grant_s;
   logic [PW-1:0]     win_idx_s;
   logic              win_any_s;
   logic              rem_req_s;
   logic              ins_req_s;
   logic              do_rem_s;
   logic              ins_slot_s;
   logic              do_ins_s;
   logic              last_was_remove_r;
   logic              out_valid_r;
   logic [RANK_W-1:0] out_rank_r;
   logic [PW-1:0]     out_port_r;
   logic [TAG_W-1:0]  out_tag_r;
`ifdef PIFO_SCHED_DROP_EN
   logic              drop_s;
   logic [NPORTS-1:0][15:0] drop_cnt_r;
`endif

   pifo_sched_rr_arb #(.NPORTS(NPORTS)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (io.in_valid),
      .advance   (ins_slot_s),
      .grant     (grant_s),
      .grant_idx (win_idx_s),
      .grant_any (win_any_s)
   );

   // Slot selection: one PIFO command per cycle, alternating under contention.
   always_comb begin
      rem_req_s = pifo_valid_out && !pifo_empty && (!out_valid_r || io.out_ready);
`ifdef PIFO_SCHED_DROP_EN
      ins_req_s = win_any_s;
`else
      // A full PIFO cannot take an insert, so it does not compete for the slot.
      ins_req_s = win_any_s && !pifo_full;
`endif
      do_rem_s   = rem_req_s && !(ins_req_s && last_was_remove_r);
      ins_slot_s = ins_req_s && !do_rem_s;
`ifdef PIFO_SCHED_DROP_EN
      drop_s   = ins_slot_s && pifo_full;
      do_ins_s = ins_slot_s && !pifo_full;
`else
      do_ins_s = ins_slot_s;
`endif
   end

   assign io.in_ready  = ins_slot_s ? grant_s : '0;
   assign pifo_insert  = do_ins_s;
   assign pifo_remove  = do_rem_s;
   assign pifo_rank_in = do_ins_s ? io.in_rank[win_idx_s*RANK_W +: RANK_W] : '0;
   assign pifo_meta_in = do_ins_s ? {win_idx_s, io.in_tag[win_idx_s*TAG_W +: TAG_W]} : '0;

   // Remembers which command took the previous slot; remove wins after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_was_remove_r <= 1'b0;
      end else begin
         last_was_remove_r <= do_rem_s;
      end
   end

   // Egress register: captures the pre-removal head; drain and refill may coincide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_r <= 1'b0;
         out_rank_r  <= '0;
         out_port_r  <= '0;
         out_tag_r   <= '0;
      end else if (do_rem_s) begin
         out_valid_r <= 1'b1;
         out_rank_r  <= pifo_rank_out;
         out_port_r  <= pifo_meta_out[META_PORT_MSB -: PW];
         out_tag_r   <= pifo_meta_out[TAG_W-1:0];
      end else if (io.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign io.out_valid = out_valid_r;
   assign io.out_rank  = out_rank_r;
   assign io.out_port  = out_port_r;
   assign io.out_tag   = out_tag_r;

`ifdef PIFO_SCHED_DROP_EN
   // Per-port drop counters, saturating at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt_r <= '0;
      end else if (drop_s && (drop_cnt_r[win_idx_s] != 16'hFFFF)) begin
         drop_cnt_r[win_idx_s] <= drop_cnt_r[win_idx_s] + 16'd1;
      end
   end

   assign drop_cnt = drop_cnt_r;
`endif
endmodule
